// File: rtl/mem_pkg.sv
// Shared types and constants for the store buffer.
//  SB_ADDR_W / SB_DATA_W : default byte-address and data widths
//  WORD_SHIFT            : byte-offset bits dropped for word matching
//  sb_entry_t            : one buffered store {valid, word address, data}
package mem_pkg;

    localparam int unsigned SB_ADDR_W  = 32;
    localparam int unsigned SB_DATA_W  = 32;
    localparam int unsigned WORD_SHIFT = 2;

    typedef struct packed {
        logic                           valid;
        logic [SB_ADDR_W-1:WORD_SHIFT]  addr;
        logic [SB_DATA_W-1:0]           data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline/DM-side bus of the store buffer.
//  st_valid/st_addr/st_data/st_ready : store push handshake
//  ld_valid/ld_addr                  : load lookup
//  ld_hit/ld_fwd_data                : combinational forwarding result
//  dm_address/dm_write_data          : DM port address/data
//  dm_memwrite/dm_memread            : DM strobes
// master = pipeline + DM side, slave = store buffer.
interface store_buffer_if
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_fwd_data;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_write_data;
    logic              dm_memwrite;
    logic              dm_memread;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_hit, ld_fwd_data, dm_address, dm_write_data,
               dm_memwrite, dm_memread
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_hit, ld_fwd_data, dm_address, dm_write_data,
               dm_memwrite, dm_memread
    );
endinterface

// File: rtl/sb_fwd_match.sv
// Youngest-match search over the store buffer entries (purely combinational).
//  entries : entry array
//  head    : index of the oldest entry
//  ld_word : load word address
//  hit     : some valid entry matches
//  data    : data of the youngest matching entry, 0 on no hit
module sb_fwd_match
    import mem_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t                     entries [DEPTH],
    input  logic [PTR_W-1:0]              head,
    input  logic [SB_ADDR_W-1:WORD_SHIFT] ld_word,
    output logic                          hit,
    output logic [SB_DATA_W-1:0]          data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (entries[idx].valid && entries[idx].addr == ld_word) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage store path and data memory.
// Stores are accepted in one cycle and drained in order whenever the DM port is
// not needed by a missing load; loads forward from the youngest matching store.
//  clk, rst : clock, asynchronous active-high reset
//  sb       : store/load/DM bus (slave side)
//  count    : occupied entries
//  empty    : no entries buffered (drain-complete fence)
module store_buffer
    import mem_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned ADDR_W = SB_ADDR_W,
    parameter  int unsigned DATA_W = SB_DATA_W,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    store_buffer_if.slave     sb,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);

    // The entry type is fixed by the package widths.
    if (ADDR_W != SB_ADDR_W || DATA_W != SB_DATA_W) begin : g_width_chk
        $error("store_buffer: ADDR_W/DATA_W must match mem_pkg widths");
    end

    sb_entry_t         entries_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic              full;
    logic              is_empty;
    logic              match_hit;
    logic [DATA_W-1:0] match_data;
    logic              ld_miss;
    logic              drain;
    logic              push;

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .entries (entries_q),
        .head    (head_q),
        .ld_word (sb.ld_addr[ADDR_W-1:WORD_SHIFT]),
        .hit     (match_hit),
        .data    (match_data)
    );

    always_comb begin
        is_empty       = (count_q == '0);
        full           = (count_q == CNT_W'(DEPTH));
        ld_miss        = sb.ld_valid & ~match_hit;
        // A missing load owns the DM port; a hit leaves it free for the drain.
        drain          = ~is_empty & ~ld_miss;
        sb.st_ready    = ~full | drain;
        push           = sb.st_valid & sb.st_ready;

        sb.ld_hit      = sb.ld_valid & match_hit;
        sb.ld_fwd_data = sb.ld_hit ? match_data : '0;
        sb.dm_memwrite = drain;
        sb.dm_memread  = ld_miss;
        sb.dm_address  = ld_miss ? sb.ld_addr
                                 : {entries_q[head_q].addr, {WORD_SHIFT{1'b0}}};
        sb.dm_write_data = entries_q[head_q].data;

        count          = count_q;
        empty          = is_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (drain) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + 1'b1;
            end
            // Ordered after the pop so a push into the slot draining at full wins.
            if (push) begin
                entries_q[tail_q] <= '{valid: 1'b1,
                                       addr:  sb.st_addr[ADDR_W-1:WORD_SHIFT],
                                       data:  sb.st_data};
                tail_q            <= tail_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(drain);
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));

    a_st_ld_together : assert property (@(posedge clk) disable iff (rst)
        !(sb.st_valid && sb.ld_valid))
        else $warning("store_buffer: protocol warning, store and load in the same cycle");

endmodule

// File: tb/tb_store_buffer.sv
// Directed + random bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
    logic       empty;

    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    store_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sb    (bus.slave),
        .count (count),
        .empty (empty)
    );

    // Data memory behind the DM port.
    logic [31:0] dm_mem [1024] = '{default: '0};
    always @(posedge clk) begin
        if (!rst && bus.dm_memwrite) dm_mem[bus.dm_address[11:2]] <= bus.dm_write_data;
    end

    // Reference model: program-ordered queue of pending stores plus expected DM image.
    ent_t        q[$];
    logic [31:0] exp_dm [1024] = '{default: '0};
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] t6_data [10];

    // Values seen during the last step, for directed spot checks.
    logic last_ready, last_hit, last_memwrite, last_memread;
    logic [31:0] last_fwd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, then advance model at the edge.
    task automatic step(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                        input bit lv, input logic [31:0] la);
        bit          hit;
        bit          miss;
        bit          drn;
        bit          rdy;
        logic [31:0] fwd;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        #1;
        hit = 1'b0;
        fwd = '0;
        if (lv) begin
            foreach (q[i]) begin
                if (q[i].addr[31:2] == la[31:2]) begin
                    hit = 1'b1;
                    fwd = q[i].data;
                end
            end
        end
        miss = lv && !hit;
        drn  = (q.size() != 0) && !miss;
        rdy  = (q.size() < DEPTH) || drn;

        last_ready    = bus.st_ready;
        last_hit      = bus.ld_hit;
        last_fwd      = bus.ld_fwd_data;
        last_memwrite = bus.dm_memwrite;
        last_memread  = bus.dm_memread;

        chk("st_ready",    bus.st_ready,    rdy);
        chk("ld_hit",      bus.ld_hit,      hit);
        chk("ld_fwd_data", bus.ld_fwd_data, fwd);
        chk("dm_memwrite", bus.dm_memwrite, drn);
        chk("dm_memread",  bus.dm_memread,  miss);
        chk("count",       count,           q.size());
        chk("empty",       empty,           q.size() == 0);
        if (miss) begin
            chk("dm_address_load", bus.dm_address, la);
        end else if (drn) begin
            chk("dm_address_drain", bus.dm_address, {q[0].addr[31:2], 2'b00});
            chk("dm_write_data",    bus.dm_write_data, q[0].data);
        end
        @(posedge clk);
        if (drn) begin
            exp_dm[q[0].addr[11:2]] = q[0].data;
            void'(q.pop_front());
        end
        if (sv && rdy) q.push_back('{addr: sa, data: sd});
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic drain_all();
        for (int k = 0; k < 2 * DEPTH && q.size() != 0; k++) idle();
        chk("drain_done_empty", empty, 1'b1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_count",       count,             0);
        chk("rst_empty",       empty,             1);
        chk("rst_st_ready",    bus.st_ready,      1);
        chk("rst_ld_hit",      bus.ld_hit,        0);
        chk("rst_memwrite",    bus.dm_memwrite,   0);
        chk("rst_memread",     bus.dm_memread,    0);
        chk("rst_dm_address",  bus.dm_address,    0);
        chk("rst_dm_wdata",    bus.dm_write_data, 0);
        rst = 1'b0;

        // Post and drain
        step(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0);
        idle();
        chk("t2_memwrite", last_memwrite, 1);
        chk("t2_empty",    empty,         1);
        chk("t2_dm16",     dm_mem[16],    32'hDEADBEEF);

        // Forwarding from the youngest of two same-word stores
        step(1'b1, 32'h80, 32'h11, 1'b1, 32'h200);
        step(1'b1, 32'h80, 32'h22, 1'b1, 32'h200);
        step(1'b0, 32'h0,  32'h0,  1'b1, 32'h83);
        chk("t3_hit",     last_hit,     1);
        chk("t3_fwd",     last_fwd,     32'h22);
        chk("t3_memread", last_memread, 0);
        drain_all();

        // Load miss holds off the drain
        step(1'b1, 32'hA0, 32'hA0A0, 1'b1, 32'h300);
        step(1'b1, 32'hA4, 32'hA4A4, 1'b1, 32'h300);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
            chk("t4_memwrite", last_memwrite, 0);
            chk("t4_count",    count,         2);
        end
        idle();
        chk("t4_resume", last_memwrite, 1);
        drain_all();

        // Full: fifth store held, then accepted in the first drain cycle
        for (int k = 0; k < 4; k++) step(1'b1, 32'hC0 + 32'(4 * k), 32'hC000 + 32'(k), 1'b1, 32'h300);
        step(1'b1, 32'hD0, 32'h55, 1'b1, 32'h300);
        chk("t5_ready_full", last_ready, 0);
        chk("t5_count_full", count,      4);
        step(1'b1, 32'hD0, 32'h55, 1'b0, 32'h0);
        chk("t5_ready_drain", last_ready,    1);
        chk("t5_memwrite",    last_memwrite, 1);
        chk("t5_count_kept",  count,         4);
        drain_all();
        chk("t5_first",  dm_mem[32'hC0 >> 2], 32'hC000);
        chk("t5_fifth",  dm_mem[32'hD0 >> 2], 32'h55);

        // Wrap: ten back-to-back stores
        for (int k = 0; k < 10; k++) begin
            t6_data[k] = $urandom;
            step(1'b1, 32'(4 * k), t6_data[k], 1'b0, 32'h0);
        end
        drain_all();
        for (int k = 0; k < 10; k++) chk("t6_dm_word", dm_mem[k], t6_data[k]);

        // Reset mid-drain with three entries pending
        for (int k = 0; k < 3; k++) step(1'b1, 32'h500 + 32'(4 * k), 32'hBAD0 + 32'(k), 1'b1, 32'h300);
        chk("t1_count3", count, 3);
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b0;
        #1;
        chk("t1_mid_drain", bus.dm_memwrite, 1);
        #1 rst = 1'b1;
        #1;
        chk("t1_count",    count,           0);
        chk("t1_empty",    empty,           1);
        chk("t1_memwrite", bus.dm_memwrite, 0);
        chk("t1_st_ready", bus.st_ready,    1);
        @(posedge clk);
        @(negedge clk);
        chk("t1_dm_unchanged", dm_mem[32'h500 >> 2], 32'h0);
        q.delete();
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bit          sv;
            bit          lv;
            logic [31:0] sa;
            logic [31:0] la;
            sv = 1'($urandom_range(0, 1));
            lv = ($urandom_range(0, 3) == 0);
            sa = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            la = ($urandom_range(0, 1) == 0)
                 ? (32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3)))
                 : (32'h300 + 32'($urandom_range(0, 15) << 2));
            step(sv, sa, $urandom, lv, la);
        end
        drain_all();
        for (int w = 0; w < 256; w++) chk("dm_image", dm_mem[w], exp_dm[w]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
